block_cipher_mmio: RTL and testbench
====================================

Name: block_cipher_mmio

Overview:
Parametrised MMIO front-end for block-cipher coprocessors. It generalises the single-block AES shell to multi-block jobs with a configurable buffer depth, block width, length register, busy/error status and an interrupt. The CPU fills an input buffer and writes CTRL. The block then streams LEN blocks through an external cipher core over valid/ready and collects the results in an output buffer. It sits on the CPU data bus at BASE_ADDR.

Parameters:
BASE_ADDR, 32'h0004_0000, bus base of the block
BUF_WORDS, 256, depth in 32-bit words of each buffer (power of 2)
BLOCK_BITS, 128, cipher block width (multiple of 32)
OUT_OFFSET, 32'h0400, byte offset of the output buffer
CTRL_OFFSET, 32'hF000, byte offset of CTRL; LEN at +4, BLK_CNT at +8

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
cpu_addr_in  input  32  byte address, word-aligned (addr[1:0] ignored)
cpu_data_in  input  32  write data
cpu_write_enable_in  input  4  per-byte write strobe; 0 = read
cpu_data_out  output  32  read data
irq_out  output  1  done & irq_en
core_valid_out  output  1  block offered to core
core_ready_in  input  1  core accepts block
core_decrypt_out  output  1  mode of offered block
core_block_out  output  BLOCK_BITS  block to core
core_result_valid_in  input  1  result strobe (single cycle)
core_result_in  input  BLOCK_BITS  result block

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: cpu_data_out=0, irq_out=0, core_valid_out=0, core_decrypt_out=0, core_block_out=0, CTRL=0, LEN=0, BLK_CNT=0, state IDLE. Buffer contents are not cleared. Reset mid-job aborts immediately to IDLE with no further core handshake.
- Address map (offsets from BASE_ADDR):
  - Input buffer at 0..4*BUF_WORDS-1.
  - Output buffer at OUT_OFFSET.., read-only.
  - CTRL, LEN, BLK_CNT as above.
  - Anything else reads 0; writes to it are dropped.
- Reads: 2-cycle latency. Address is sampled at edge N; cpu_data_out is valid after edge N+2 and holds until the next read completes.
- Writes: byte strobes honoured. Input-buffer writes are dropped while busy.
- CTRL bits:
  - bit0: start encrypt, write-1 pulse.
  - bit1: start decrypt, write-1 pulse.
  - bit2: done, RO; write-1-to-clear.
  - bit3: busy, RO.
  - bit4: error, RO; cleared on the next accepted start.
  - bit5: irq_en, RW.
- Start rules:
  - Accepted only when not busy and exactly one of bit0/bit1 is 1.
  - Both set → error=1, done=1, no job.
  - Start while busy is ignored entirely.
  - LEN=0 or LEN > BUF_WORDS*32/BLOCK_BITS → error=1, done=1, no core traffic.
- Block layout: W = BLOCK_BITS/32 words per block. Block k occupies input words k*W..k*W+W-1. The lowest-address word is the most-significant 32 bits. The output buffer uses the same layout.
- FSM:
  - IDLE → LOAD on an accepted start (busy=1, done=0, BLK_CNT=0).
  - LOAD: reads W words, one per cycle, and assembles core_block_out. Total W+1 cycles (BRAM latency), then ISSUE.
  - ISSUE: core_valid_out=1 with block and mode held stable until core_ready_in. On the handshake cycle → WAIT and core_valid_out drops.
  - WAIT: on core_result_valid_in, capture core_result_in → STORE. Result strobes outside WAIT are ignored.
  - STORE: writes W words, one per cycle, then BLK_CNT++. If BLK_CNT==LEN → DONE, else → LOAD.
  - DONE: busy=0, done=1 → IDLE.
- Concurrency: one block in flight at a time. The CPU port has priority for the output-buffer read port; the FSM owns the buffer ports it uses internally.
- Writing LEN while busy is dropped.
- irq_out is combinational on the registered bits: done & irq_en.

Decomposition:
- Package crypto_mmio_pkg holds:
  - address offset constants;
  - CTRL bit indices (CTRL_ENC, CTRL_DEC, CTRL_DONE, CTRL_BUSY, CTRL_ERR, CTRL_IRQEN);
  - state enum (IDLE, LOAD, ISSUE, WAIT, STORE, DONE).
- Sub-module mmio_word_buffer is instantiated twice (input, output). It is a parametrised-depth simple dual-port RAM with byte strobes and 1-cycle registered read.

Test Plan:
- Test core model: result = block ^ {W{32'hFFFF_FFFF}}, ready after 3 cycles, result 5 cycles after accept.
- Single block: write 00112233,44556677,8899aabb,ccddeeff; LEN=1; CTRL=1 → poll until done. Required: output words ffeeddcc,bbaa9988,77665544,33221100; core_decrypt_out=0; BLK_CNT=1.
- Multi-block decrypt: LEN=4 with 16 distinct words; CTRL=2, irq_en=1. Required: exactly 4 core handshakes with core_decrypt_out=1, irq_out rises with done, 16 inverted output words in order.
- Errors:
  - LEN=0 with CTRL=1 → done=1, error=1, core_valid_out never asserted.
  - LEN=65 (BUF_WORDS=256) → same response.
  - CTRL=3 → same response.
- Busy protection: during a LEN=2 job, write input word 0 = deadbeef and CTRL=1. Required: job result unchanged, no second job, word 0 still holds its old value.
- Backpressure and reset: hold core_ready_in=0 for 20 cycles. Required: block stable and valid held. Then assert rst_in mid-WAIT → next cycle state IDLE, CTRL reads 0, core_valid_out=0.
- Bus: byte strobe 4'b0010 writing 0000ab00 over 11111111 → reads 1111ab11 two cycles later; unmapped 0x4_8000 reads 0; done W1C clears bit2.

Source files
------------

// File: rtl/crypto_mmio_pkg.sv
// Shared constants, CTRL bit map and FSM states
// for the block-cipher MMIO front-end.
package crypto_mmio_pkg;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0004_0000;
  localparam logic [31:0] DEF_OUT_OFFSET  = 32'h0000_0400;
  localparam logic [31:0] DEF_CTRL_OFFSET = 32'h0000_F000;
  localparam logic [31:0] LEN_DELTA       = 32'd4;
  localparam logic [31:0] CNT_DELTA       = 32'd8;

  localparam int CTRL_ENC   = 0;
  localparam int CTRL_DEC   = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_BUSY  = 3;
  localparam int CTRL_ERR   = 4;
  localparam int CTRL_IRQEN = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_IN,
    SEL_OUT,
    SEL_CTRL,
    SEL_LEN,
    SEL_CNT
  } sel_e;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] cur,
    input logic [31:0] val,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mmio_word_buffer.sv
// Simple dual-port word RAM: byte-strobed write
// port, registered 1-cycle read port.
module mmio_word_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/block_cipher_mmio.sv
// MMIO shell streaming LEN blocks from an input
// buffer through an external cipher core.
module block_cipher_mmio
  import crypto_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          BUF_WORDS   = 256,
  parameter int          BLOCK_BITS  = 128,
  parameter logic [31:0] OUT_OFFSET  = DEF_OUT_OFFSET,
  parameter logic [31:0] CTRL_OFFSET = DEF_CTRL_OFFSET
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           cpu_addr_in,
  input  logic [31:0]           cpu_data_in,
  input  logic [3:0]            cpu_write_enable_in,
  output logic [31:0]           cpu_data_out,
  output logic                  irq_out,
  output logic                  core_valid_out,
  input  logic                  core_ready_in,
  output logic                  core_decrypt_out,
  output logic [BLOCK_BITS-1:0] core_block_out,
  input  logic                  core_result_valid_in,
  input  logic [BLOCK_BITS-1:0] core_result_in
);

  localparam int W    = BLOCK_BITS / 32;
  localparam int AW   = $clog2(BUF_WORDS);
  localparam int CW   = $clog2(W + 1);
  localparam int MAXB = BUF_WORDS * 32 / BLOCK_BITS;
  localparam logic [31:0] OUT_W  = OUT_OFFSET >> 2;
  localparam logic [31:0] CTRL_W = CTRL_OFFSET >> 2;
  localparam logic [31:0] LEN_W  = (CTRL_OFFSET + LEN_DELTA) >> 2;
  localparam logic [31:0] CNT_W  = (CTRL_OFFSET + CNT_DELTA) >> 2;

  state_e state, state_nx;
  sel_e   sel, sel1, sel2;

  logic [31:0] off, offw;
  logic        wr, busy;
  logic [AW-1:0] in_idx, out_idx, idx1;
  logic        rd_v1, rd_v2;

  logic [31:0] len, blk_cnt, blk_nx;
  logic        done, err, irq_en, mode;
  logic [CW-1:0] cnt;
  logic [BLOCK_BITS-1:0] res;

  logic        ctrl_wr, enc, dec, len_ok;
  logic        start_try, go, ld_last, st_last;
  logic [AW-1:0] word_base, fsm_addr, in_raddr;
  logic [3:0]  in_we;
  logic [31:0] in_q, out_q, ctrl_rd, rd_val;

  assign off  = cpu_addr_in - BASE_ADDR;
  assign offw = off >> 2;
  assign wr   = |cpu_write_enable_in;
  assign busy = state inside {LOAD, ISSUE, WAIT, STORE};

  assign in_idx  = AW'(offw);
  assign out_idx = AW'(offw - OUT_W);

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (offw < 32'(BUF_WORDS)):   sel = SEL_IN;
      (offw >= OUT_W &&
       offw < OUT_W + 32'(BUF_WORDS)): sel = SEL_OUT;
      (offw == CTRL_W):          sel = SEL_CTRL;
      (offw == LEN_W):           sel = SEL_LEN;
      (offw == CNT_W):           sel = SEL_CNT;
      default:                   sel = SEL_NONE;
    endcase
  end

  // CTRL bits all live in byte 0
  assign ctrl_wr = sel == SEL_CTRL && cpu_write_enable_in[0];
  assign enc     = ctrl_wr && cpu_data_in[CTRL_ENC];
  assign dec     = ctrl_wr && cpu_data_in[CTRL_DEC];
  assign len_ok  = len != '0 && len <= 32'(MAXB);
  assign start_try = state == IDLE && (enc || dec);
  assign go      = start_try && (enc ^ dec) && len_ok;

  assign blk_nx    = blk_cnt + 32'd1;
  assign word_base = AW'(blk_cnt * W);
  assign fsm_addr  = word_base + AW'(cnt);
  assign ld_last   = cnt == CW'(W);
  assign st_last   = cnt == CW'(W - 1);

  assign in_we    = (sel == SEL_IN && !busy) ?
                    cpu_write_enable_in : 4'b0;
  assign in_raddr = (state == LOAD) ? fsm_addr : idx1;

  mmio_word_buffer #(.DEPTH(BUF_WORDS)) u_in_buf (
    .clk   (clk_in),
    .we    (in_we),
    .waddr (in_idx),
    .wdata (cpu_data_in),
    .raddr (in_raddr),
    .rdata (in_q)
  );

  mmio_word_buffer #(.DEPTH(BUF_WORDS)) u_out_buf (
    .clk   (clk_in),
    .we    ((state == STORE) ? 4'hF : 4'h0),
    .waddr (fsm_addr),
    .wdata (res[BLOCK_BITS-1 -: 32]),
    .raddr (idx1),
    .rdata (out_q)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (go) state_nx = LOAD;
      LOAD:  if (ld_last) state_nx = ISSUE;
      ISSUE: if (core_ready_in) state_nx = WAIT;
      WAIT:  if (core_result_valid_in) state_nx = STORE;
      STORE: if (st_last)
               state_nx = (blk_nx == len) ? DONE : LOAD;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign core_valid_out   = state == ISSUE;
  assign core_decrypt_out = mode;
  assign irq_out          = done & irq_en;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt            <= '0;
      blk_cnt        <= '0;
      len            <= '0;
      mode           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      irq_en         <= 1'b0;
      res            <= '0;
      core_block_out <= '0;
    end else begin
      if (state != state_nx)
        cnt <= '0;
      else if (state == LOAD || state == STORE)
        cnt <= cnt + CW'(1);
      // RAM data lags the address by one cycle
      if (state == LOAD && cnt != '0)
        core_block_out <= (core_block_out << 32) |
                          BLOCK_BITS'(in_q);
      if (state == WAIT && core_result_valid_in)
        res <= core_result_in;
      else if (state == STORE)
        res <= res << 32;
      if (sel == SEL_LEN && wr && !busy)
        len <= merge_bytes(len, cpu_data_in,
                           cpu_write_enable_in);
      if (ctrl_wr) begin
        irq_en <= cpu_data_in[CTRL_IRQEN];
        if (cpu_data_in[CTRL_DONE]) done <= 1'b0;
      end
      if (state == STORE && st_last) begin
        blk_cnt <= blk_nx;
        if (blk_nx == len) done <= 1'b1;
      end
      if (start_try) begin
        if ((enc && dec) || !len_ok) begin
          err  <= 1'b1;
          done <= 1'b1;
        end else begin
          err     <= 1'b0;
          done    <= 1'b0;
          blk_cnt <= '0;
          mode    <= dec;
        end
      end
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_DONE]  = done;
    ctrl_rd[CTRL_BUSY]  = busy;
    ctrl_rd[CTRL_ERR]   = err;
    ctrl_rd[CTRL_IRQEN] = irq_en;
  end

  always_comb begin
    rd_val = '0;
    unique case (sel2)
      SEL_IN:   rd_val = in_q;
      SEL_OUT:  rd_val = out_q;
      SEL_CTRL: rd_val = ctrl_rd;
      SEL_LEN:  rd_val = len;
      SEL_CNT:  rd_val = blk_cnt;
      default:  rd_val = '0;
    endcase
  end

  // address stage, RAM stage, output stage
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_v1        <= 1'b0;
      rd_v2        <= 1'b0;
      sel1         <= SEL_NONE;
      sel2         <= SEL_NONE;
      idx1         <= '0;
      cpu_data_out <= '0;
    end else begin
      rd_v1 <= !wr;
      sel1  <= sel;
      idx1  <= (sel == SEL_OUT) ? out_idx : in_idx;
      rd_v2 <= rd_v1;
      sel2  <= sel1;
      if (rd_v2) cpu_data_out <= rd_val;
    end
  end

endmodule

// File: tb/tb_block_cipher_mmio.sv
// Directed bench for block_cipher_mmio with an
// inverting test core and an output scoreboard.
module tb_block_cipher_mmio;

  localparam logic [31:0] BASE = 32'h0004_0000;
  localparam logic [31:0] OUTB = BASE + 32'h0400;
  localparam logic [31:0] CTRL = BASE + 32'hF000;
  localparam logic [31:0] LENA = CTRL + 32'd4;
  localparam logic [31:0] CNTA = CTRL + 32'd8;

  logic         clk = 1'b0;
  logic         rst_in = 1'b1;
  logic [31:0]  cpu_addr_in = '0;
  logic [31:0]  cpu_data_in = '0;
  logic [3:0]   cpu_write_enable_in = '0;
  logic [31:0]  cpu_data_out;
  logic         irq_out;
  logic         core_valid_out;
  logic         core_ready_in = 1'b0;
  logic         core_decrypt_out;
  logic [127:0] core_block_out;
  logic         core_result_valid_in = 1'b0;
  logic [127:0] core_result_in = '0;

  int checks = 0;
  int failures = 0;
  int hs = 0;
  int hs_dec = 0;
  int vcount = 0;
  int vcnt = 0;
  int rtimer = 0;
  bit stall = 1'b0;
  logic [127:0] blk_hold = '0;
  logic [31:0] exp_q[$];

  block_cipher_mmio dut (
    .clk_in               (clk),
    .rst_in               (rst_in),
    .cpu_addr_in          (cpu_addr_in),
    .cpu_data_in          (cpu_data_in),
    .cpu_write_enable_in  (cpu_write_enable_in),
    .cpu_data_out         (cpu_data_out),
    .irq_out              (irq_out),
    .core_valid_out       (core_valid_out),
    .core_ready_in        (core_ready_in),
    .core_decrypt_out     (core_decrypt_out),
    .core_block_out       (core_block_out),
    .core_result_valid_in (core_result_valid_in),
    .core_result_in       (core_result_in)
  );

  always #5 clk = ~clk;

  // test core: ready after 3 valid cycles,
  // inverted result 5 cycles after accept
  always @(negedge clk) begin
    core_result_valid_in = 1'b0;
    if (core_valid_out) vcount++;
    if (rst_in) begin
      core_ready_in = 1'b0;
      vcnt = 0;
      rtimer = 0;
    end else begin
      if (rtimer > 0) begin
        rtimer--;
        if (rtimer == 0) begin
          core_result_valid_in = 1'b1;
          core_result_in = ~blk_hold;
        end
      end
      if (core_ready_in) begin
        hs++;
        if (core_decrypt_out) hs_dec++;
        blk_hold = core_block_out;
        core_ready_in = 1'b0;
        vcnt = 0;
        rtimer = 5;
      end else if (core_valid_out && !stall) begin
        vcnt++;
        if (vcnt >= 3) core_ready_in = 1'b1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be = 4'hF);
    @(posedge clk); #1;
    cpu_addr_in = a;
    cpu_data_in = d;
    cpu_write_enable_in = be;
    @(posedge clk); #1;
    cpu_write_enable_in = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    @(posedge clk); #1;
    cpu_addr_in = a;
    cpu_write_enable_in = 4'h0;
    repeat (3) @(posedge clk);
    #1 d = cpu_data_out;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] v;
    v = '0;
    for (int n = 0; n < 200 && !v[2]; n++)
      rd(CTRL, v);
    check(tag, v[2], 1'b1);
  endtask

  task automatic drain(input string tag, input int n);
    logic [31:0] v, e;
    for (int i = 0; i < n; i++) begin
      rd(OUTB + 32'(4 * i), v);
      e = exp_q.pop_front();
      check(tag, v, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, w0;
    logic [127:0] b0;
    int h0, d0, vc0, n;
    bit stable;
    logic [31:0] sw[4];
    logic [31:0] err_len[3];
    logic [31:0] err_ctl[3];

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", cpu_data_out, 32'h0);
    check("rst_irq", irq_out, 1'b0);
    check("rst_valid", core_valid_out, 1'b0);
    check("rst_dec", core_decrypt_out, 1'b0);
    check("rst_block", core_block_out, 128'h0);
    rst_in = 1'b0;
    rd(CTRL, v);
    check("rst_ctrl", v, 32'h0);
    rd(LENA, v);
    check("rst_len", v, 32'h0);

    wr(BASE + 32'd20, 32'h1111_1111);
    wr(BASE + 32'd20, 32'h0000_ab00, 4'b0010);
    rd(BASE + 32'd20, v);
    check("byte_strobe", v, 32'h1111_ab11);
    wr(32'h0004_8000, 32'hFFFF_FFFF);
    rd(32'h0004_8000, v);
    check("unmapped", v, 32'h0);

    sw[0] = 32'h0011_2233;
    sw[1] = 32'h4455_6677;
    sw[2] = 32'h8899_aabb;
    sw[3] = 32'hccdd_eeff;
    for (int i = 0; i < 4; i++) begin
      wr(BASE + 32'(4 * i), sw[i]);
      exp_q.push_back(~sw[i]);
    end
    wr(LENA, 32'd1);
    h0 = hs;
    d0 = hs_dec;
    wr(CTRL, 32'h1);
    wait_done("single_done");
    rd(CNTA, v);
    check("single_cnt", v, 32'd1);
    check("single_hs", hs - h0, 1);
    check("single_mode", hs_dec - d0, 0);
    rd(CTRL, v);
    check("single_ctrl", v, 32'h04);
    check("single_irq", irq_out, 1'b0);
    drain("single_out", 4);

    for (int i = 0; i < 16; i++) begin
      v = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      wr(BASE + 32'(4 * i), v);
      exp_q.push_back(~v);
    end
    wr(LENA, 32'd4);
    h0 = hs;
    d0 = hs_dec;
    wr(CTRL, 32'h22);
    check("multi_irq_lo", irq_out, 1'b0);
    wait_done("multi_done");
    check("multi_irq_hi", irq_out, 1'b1);
    check("multi_hs", hs - h0, 4);
    check("multi_dec", hs_dec - d0, 4);
    rd(CNTA, v);
    check("multi_cnt", v, 32'd4);
    drain("multi_out", 16);

    err_len[0] = 32'd0;  err_ctl[0] = 32'h1;
    err_len[1] = 32'd65; err_ctl[1] = 32'h1;
    err_len[2] = 32'd1;  err_ctl[2] = 32'h3;
    for (int k = 0; k < 3; k++) begin
      wr(CTRL, 32'h4);
      vc0 = vcount;
      wr(LENA, err_len[k]);
      wr(CTRL, err_ctl[k]);
      repeat (10) @(posedge clk);
      rd(CTRL, v);
      check("err_ctrl", v, 32'h14);
      check("err_novalid", vcount - vc0, 0);
    end
    wr(CTRL, 32'h4);
    rd(CTRL, v);
    check("done_w1c", v, 32'h10);

    for (int i = 0; i < 8; i++) begin
      v = 32'ha0a0_0000 + 32'(i);
      wr(BASE + 32'(4 * i), v);
      exp_q.push_back(~v);
    end
    wr(LENA, 32'd2);
    h0 = hs;
    wr(CTRL, 32'h1);
    wr(BASE, 32'hdead_beef);
    wr(CTRL, 32'h1);
    wr(LENA, 32'd3);
    wait_done("busy_done");
    rd(CNTA, v);
    check("busy_cnt", v, 32'd2);
    rd(LENA, v);
    check("busy_len", v, 32'd2);
    repeat (40) @(posedge clk);
    check("busy_hs", hs - h0, 2);
    rd(CTRL, v);
    check("busy_ctrl", v, 32'h04);
    rd(BASE, w0);
    check("busy_word0", w0, 32'ha0a0_0000);
    drain("busy_out", 8);

    wr(LENA, 32'd1);
    stall = 1'b1;
    h0 = hs;
    wr(CTRL, 32'h1);
    for (n = 0; n < 50 && !core_valid_out; n++)
      @(negedge clk);
    check("bp_valid", core_valid_out, 1'b1);
    b0 = core_block_out;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!core_valid_out || core_block_out !== b0)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_block", b0,
          {32'ha0a0_0000, 32'ha0a0_0001,
           32'ha0a0_0002, 32'ha0a0_0003});
    check("bp_nohs", hs - h0, 0);
    stall = 1'b0;
    for (n = 0; n < 20 && hs == h0; n++)
      @(negedge clk);
    check("bp_hs", hs - h0, 1);
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    check("rst_mid_valid", core_valid_out, 1'b0);
    vc0 = vcount;
    rd(CTRL, v);
    check("rst_mid_ctrl", v, 32'h0);
    rd(CNTA, v);
    check("rst_mid_cnt", v, 32'h0);
    repeat (20) @(posedge clk);
    check("rst_mid_nohs", hs - h0, 1);
    check("rst_mid_novalid", vcount - vc0, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
